// File: rtl/fwd_pkg.sv
// Shared kinds, stage record and default widths for the forwarding result tracker.
package fwd_pkg;

  localparam int unsigned DEF_XLEN   = 32;
  localparam int unsigned DEF_REG_AW = 5;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_MUL  = 2'd2
  } kind_e;

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic                  we;
    kind_e                 kind;
    logic [DEF_XLEN-1:0]   data;
    logic                  done;
  } stage_t;

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage record: load wins over bubble, otherwise the record holds.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   bubble_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t rec_q, rec_d;

  always_comb begin
    rec_d = rec_q;
    if (load_i)        rec_d = d_i;
    else if (bubble_i) rec_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rec_q <= '0;
    else     rec_q <= rec_d;
  end

  assign q_o = rec_q;

endmodule

// File: rtl/fwd_result_tracker.sv
// Tracks in-flight results through S1 (EX/MEM) and S2 (MEM/WB), drives forwarding
// sources and the register-file write port, and stalls issue on load-use / pending MUL.
module fwd_result_tracker
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN   = DEF_XLEN,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_we,
  input  logic [1:0]        issue_kind,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mul_done,
  input  logic [XLEN-1:0]   mul_result,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [REG_AW-1:0] rd1,
  output logic [REG_AW-1:0] rd2,
  output logic              rd_valid1,
  output logic              rd_valid2,
  output logic [XLEN-1:0]   rwdata1,
  output logic [XLEN-1:0]   rwdata2,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              stall
);

  stage_t s1_q, s2_q, s1_d;
  logic   s1_load, s1_bubble;
  logic   s1_complete, load_use, accept, mul_fill;
  logic   unused_s2_done;

  always_comb begin
    s1_complete = !s1_q.valid || (s1_q.kind != KIND_MUL) || s1_q.done;
    load_use    = s1_q.valid && (s1_q.kind == KIND_LOAD) && s1_q.we && (s1_q.rd != '0)
                  && ((issue_rs1 == s1_q.rd) || (issue_rs2 == s1_q.rd));
    issue_ready = s1_complete && !load_use;
    accept      = issue_valid && issue_ready;
    // mul_fill only happens while S1 is blocked, so it never collides with an accept
    mul_fill    = s1_q.valid && (s1_q.kind == KIND_MUL) && !s1_q.done && mul_done;

    s1_d = '0;
    if (mul_fill) begin
      s1_d      = s1_q;
      s1_d.done = 1'b1;
      s1_d.data = mul_result;
    end else begin
      s1_d.valid = 1'b1;
      s1_d.rd    = issue_rd;
      s1_d.we    = issue_we;
      s1_d.kind  = kind_e'(issue_kind);
      s1_d.data  = ex_result;
    end
    s1_load   = (s1_complete && accept) || mul_fill;
    s1_bubble = s1_complete && !accept;
  end

  fwd_stage_reg u_s1 (
    .clk      (clk),
    .rst      (reset),
    .load_i   (s1_load),
    .bubble_i (s1_bubble),
    .d_i      (s1_d),
    .q_o      (s1_q)
  );

  fwd_stage_reg u_s2 (
    .clk      (clk),
    .rst      (reset),
    .load_i   (s1_complete),
    .bubble_i (!s1_complete),
    .d_i      (s1_q),
    .q_o      (s2_q)
  );

  always_comb begin
    rd1       = s1_q.rd;
    rd2       = s2_q.rd;
    rwdata1   = s1_q.data;
    rd_valid1 = s1_q.valid && s1_q.we && (s1_q.rd != '0)
                && ((s1_q.kind == KIND_ALU) || ((s1_q.kind == KIND_MUL) && s1_q.done));
    rd_valid2 = s2_q.valid && s2_q.we && (s2_q.rd != '0);
    rwdata2   = (s2_q.kind == KIND_LOAD) ? mem_rdata : s2_q.data;
    wb_we     = rd_valid2;
    wb_rd     = s2_q.rd;
    wb_data   = rwdata2;
    stall     = !issue_ready;
  end

  assign unused_s2_done = s2_q.done;

endmodule
